// File: rtl/lsu_pkg.sv
// Shared types and codes for the load/store unit and its alignment helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;
  localparam logic [1:0] W_D = 2'd3;

  localparam logic [1:0] F_NONE  = 2'd0;
  localparam logic [1:0] F_MISAL = 2'd1;
  localparam logic [1:0] F_BUS   = 2'd2;
  localparam logic [1:0] F_ILL   = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store replication,
// load extract and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        width,
  input  logic [2:0]        low3,
  input  logic              uns,
  input  logic [XLEN-1:0]   sdata,
  input  logic [XLEN-1:0]   rdata,
  output logic              misal,
  output logic              ill,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW-1:0]   off;
  logic [NB-1:0]   mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  assign off = low3[OW-1:0];
  assign ill = (width == W_D) && (XLEN == 32);

  always_comb begin
    mask    = '1;
    keep    = '1;
    sign    = 1'b0;
    misal   = 1'b0;
    wdata   = sdata;
    shifted = rdata >> {off, 3'b000};
    case (width)
      W_B: begin
        mask  = NB'(1);
        keep  = XLEN'(8'hFF);
        sign  = shifted[7];
        wdata = {NB{sdata[7:0]}};
      end
      W_H: begin
        mask  = NB'(3);
        keep  = XLEN'(16'hFFFF);
        sign  = shifted[15];
        misal = low3[0];
        wdata = {(XLEN/16){sdata[15:0]}};
      end
      W_W: begin
        mask  = NB'(15);
        keep  = XLEN'(32'hFFFF_FFFF);
        sign  = shifted[31];
        misal = |low3[1:0];
        wdata = {(XLEN/32){sdata[31:0]}};
      end
      default: begin
        sign  = shifted[XLEN-1];
        misal = |low3;
      end
    endcase
    be    = mask << off;
    // Extension fills every bit above the access width with the sign bit.
    ldata = (shifted & keep) | ((sign && !uns) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_bus.sv
// Multi-cycle load/store unit: request/response bus FSM with timeout,
// stalling the core while an access is outstanding.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Load_1,
  input  logic              i_Store_1,
  input  logic              i_LoadUnsigned_1,
  input  logic [1:0]        i_LoadStoreWidth_2,
  input  logic [AW-1:0]     i_Addr_32,
  input  logic [XLEN-1:0]   i_StoreData_32,
  output logic              o_Stall_1,
  output logic              o_Done_1,
  output logic [1:0]        o_Fault_2,
  output logic [XLEN-1:0]   o_LoadData_32,
  output logic              o_BusReq_1,
  input  logic              i_BusGnt_1,
  output logic [AW-1:0]     o_BusAddr_32,
  output logic              o_BusWe_1,
  output logic [XLEN/8-1:0] o_BusBe_8,
  output logic [XLEN-1:0]   o_BusWdata_32,
  input  logic              i_BusRvalid_1,
  input  logic [XLEN-1:0]   i_BusRdata_32,
  input  logic              i_BusErr_1
);

  localparam int NB = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t          state, next;
  logic [CW-1:0]   cnt;
  logic [1:0]      width_q;
  logic [2:0]      off_q;
  logic            uns_q;
  logic [1:0]      fault_q;
  logic [XLEN-1:0] ldata_q;

  logic            req_in, tmo, ill, a_ill, a_misal;
  logic [1:0]      a_width;
  logic [2:0]      a_low3;
  logic [NB-1:0]   a_be;
  logic [XLEN-1:0] a_wdata, a_ldata;

  assign req_in = i_Load_1 | i_Store_1;
  assign tmo    = (cnt == CW'(TIMEOUT - 1));
  assign ill    = (i_Load_1 & i_Store_1) | a_ill;

  // Live core controls drive the checker in IDLE; latched ones drive the load extract.
  assign a_width = (state == IDLE) ? i_LoadStoreWidth_2 : width_q;
  assign a_low3  = (state == IDLE) ? i_Addr_32[2:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .width (a_width),
    .low3  (a_low3),
    .uns   (uns_q),
    .sdata (i_StoreData_32),
    .rdata (i_BusRdata_32),
    .misal (a_misal),
    .ill   (a_ill),
    .be    (a_be),
    .wdata (a_wdata),
    .ldata (a_ldata)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE: if (req_in) next = (ill || a_misal) ? DONE : REQ;
      REQ: begin
        if (tmo)             next = DONE;
        else if (i_BusGnt_1) next = RESP;
      end
      RESP: if (i_BusRvalid_1 || tmo) next = DONE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      width_q       <= '0;
      off_q         <= '0;
      uns_q         <= 1'b0;
      fault_q       <= F_NONE;
      ldata_q       <= '0;
      o_BusAddr_32  <= '0;
      o_BusWe_1     <= 1'b0;
      o_BusBe_8     <= '0;
      o_BusWdata_32 <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (req_in) begin
            ldata_q <= '0;
            fault_q <= ill ? F_ILL : (a_misal ? F_MISAL : F_NONE);
            if (!ill && !a_misal) begin
              o_BusAddr_32  <= i_Addr_32 & ~AW'(NB - 1);
              o_BusWe_1     <= i_Store_1;
              o_BusBe_8     <= a_be;
              o_BusWdata_32 <= a_wdata;
              width_q       <= i_LoadStoreWidth_2;
              off_q         <= i_Addr_32[2:0];
              uns_q         <= i_LoadUnsigned_1;
              cnt           <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (tmo) fault_q <= F_BUS;
        end
        RESP: begin
          cnt <= cnt + 1'b1;
          if (i_BusRvalid_1) begin
            if (i_BusErr_1)     fault_q <= F_BUS;
            else if (!o_BusWe_1) ldata_q <= a_ldata;
          end else if (tmo) begin
            fault_q <= F_BUS;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Done_1      = (state == DONE);
  assign o_BusReq_1    = (state == REQ);
  assign o_Fault_2     = fault_q;
  assign o_LoadData_32 = ldata_q;
  assign o_Stall_1     = !rst && ((state == REQ) || (state == RESP) ||
                                  ((state == IDLE) && req_in));

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: one XLEN=32 and one XLEN=64 instance, both TIMEOUT=8.
module tb_lsu_bus;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0, store = 1'b0, uns = 1'b0;
  logic [1:0]  width = 2'd0;
  logic [31:0] addr = '0;
  logic [63:0] sdata = '0;
  logic        gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [63:0] rdata = '0;
  bit          sel64 = 1'b0;

  logic        stall32, done32, req32, we32;
  logic [1:0]  fault32;
  logic [31:0] ld32, baddr32, wd32;
  logic [3:0]  be32;
  logic        stall64, done64, req64, we64;
  logic [1:0]  fault64;
  logic [63:0] ld64, wd64;
  logic [31:0] baddr64;
  logic [7:0]  be64;

  logic        o_stall, o_done, o_req, o_we;
  logic [1:0]  o_fault;
  logic [63:0] o_ld, o_wd;
  logic [31:0] o_addr;
  logic [7:0]  o_be;

  assign o_stall = sel64 ? stall64 : stall32;
  assign o_done  = sel64 ? done64 : done32;
  assign o_req   = sel64 ? req64 : req32;
  assign o_we    = sel64 ? we64 : we32;
  assign o_fault = sel64 ? fault64 : fault32;
  assign o_ld    = sel64 ? ld64 : {32'h0, ld32};
  assign o_wd    = sel64 ? wd64 : {32'h0, wd32};
  assign o_addr  = sel64 ? baddr64 : baddr32;
  assign o_be    = sel64 ? be64 : {4'h0, be32};

  lsu_bus #(.XLEN(32), .AW(32), .TIMEOUT(8)) dut32 (
    .clk(clk), .rst(rst), .i_Load_1(load), .i_Store_1(store),
    .i_LoadUnsigned_1(uns), .i_LoadStoreWidth_2(width), .i_Addr_32(addr),
    .i_StoreData_32(sdata[31:0]), .o_Stall_1(stall32), .o_Done_1(done32),
    .o_Fault_2(fault32), .o_LoadData_32(ld32), .o_BusReq_1(req32),
    .i_BusGnt_1(gnt), .o_BusAddr_32(baddr32), .o_BusWe_1(we32),
    .o_BusBe_8(be32), .o_BusWdata_32(wd32), .i_BusRvalid_1(rvalid),
    .i_BusRdata_32(rdata[31:0]), .i_BusErr_1(err)
  );

  lsu_bus #(.XLEN(64), .AW(32), .TIMEOUT(8)) dut64 (
    .clk(clk), .rst(rst), .i_Load_1(load), .i_Store_1(store),
    .i_LoadUnsigned_1(uns), .i_LoadStoreWidth_2(width), .i_Addr_32(addr),
    .i_StoreData_32(sdata), .o_Stall_1(stall64), .o_Done_1(done64),
    .o_Fault_2(fault64), .o_LoadData_32(ld64), .o_BusReq_1(req64),
    .i_BusGnt_1(gnt), .o_BusAddr_32(baddr64), .o_BusWe_1(we64),
    .o_BusBe_8(be64), .o_BusWdata_32(wd64), .i_BusRvalid_1(rvalid),
    .i_BusRdata_32(rdata), .i_BusErr_1(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_done_cyc, r_stall;
  bit          r_req, r_we, r_req_at_done;
  logic [31:0] r_addr;
  logic [7:0]  r_be;
  logic [63:0] r_wdata, r_ldata;
  logic [1:0]  r_fault;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Runs one access from a fresh reset; cycle 0 is the cycle the request is presented.
  task automatic do_access(input bit s64, input bit ld, input bit st, input bit un,
                           input logic [1:0] w, input logic [31:0] a, input logic [63:0] sd,
                           input int gnt_dly, input bit resp, input bit e,
                           input logic [63:0] rd);
    int  reqc;
    bit  pend;
    pulse_reset();
    sel64 = s64; load = ld; store = st; uns = un; width = w; addr = a; sdata = sd;
    r_done_cyc = -1; r_stall = 0; r_req = 0; r_we = 0; r_req_at_done = 0;
    r_addr = '0; r_be = '0; r_wdata = '0; r_ldata = '0; r_fault = '0;
    reqc = 0; pend = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
      if (pend) begin
        pend = 0;
        if (resp) begin rvalid = 1'b1; err = e; rdata = rd; end
      end
      if (o_stall) r_stall++;
      if (o_req) begin
        r_req = 1; r_addr = o_addr; r_be = o_be; r_we = o_we; r_wdata = o_wd;
        reqc++;
        if (reqc > gnt_dly) begin gnt = 1'b1; pend = 1; end
      end
      if (o_done) begin
        r_done_cyc = c; r_fault = o_fault; r_ldata = o_ld; r_req_at_done = o_req;
        load = 1'b0; store = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    pulse_reset();
    @(negedge clk);
    check("rst_done",  done32,  1'b0);
    check("rst_stall", stall32, 1'b0);
    check("rst_req",   req32,   1'b0);
    check("rst_fault", fault32, 2'd0);
    check("rst_ld",    ld32,    32'h0);

    // LB 0x103
    do_access(0, 1, 0, 0, W_B, 32'h103, 64'h0, 0, 1, 0, 64'h80FF_0000);
    check("lb_done",  r_done_cyc, 3);
    check("lb_stall", r_stall,    3);
    check("lb_addr",  r_addr,     32'h100);
    check("lb_be",    r_be,       8'h08);
    check("lb_we",    r_we,       1'b0);
    check("lb_fault", r_fault,    F_NONE);
    check("lb_data",  r_ldata,    64'hFFFF_FF80);

    // LBU 0x103
    do_access(0, 1, 0, 1, W_B, 32'h103, 64'h0, 0, 1, 0, 64'h80FF_0000);
    check("lbu_data", r_ldata, 64'h0000_0080);

    // LH 0x102
    do_access(0, 1, 0, 0, W_H, 32'h102, 64'h0, 0, 1, 0, 64'h8001_1234);
    check("lh_data", r_ldata, 64'hFFFF_8001);

    // SH 0x102
    do_access(0, 0, 1, 0, W_H, 32'h102, 64'h1234_ABCD, 0, 1, 0, 64'hDEAD_BEEF);
    check("sh_we",    r_we,       1'b1);
    check("sh_be",    r_be,       8'h0C);
    check("sh_wdata", r_wdata,    64'hABCD_ABCD);
    check("sh_stall", r_stall,    3);
    check("sh_done",  r_done_cyc, 3);
    check("sh_data",  r_ldata,    64'h0);

    // LW 0x101 misaligned
    do_access(0, 1, 0, 0, W_W, 32'h101, 64'h0, 0, 1, 0, 64'hFFFF_FFFF);
    check("mis_fault", r_fault,    F_MISAL);
    check("mis_done",  r_done_cyc, 1);
    check("mis_stall", r_stall,    1);
    check("mis_req",   r_req,      1'b0);
    check("mis_data",  r_ldata,    64'h0);

    // Width 3 at XLEN=32
    do_access(0, 1, 0, 0, W_D, 32'h100, 64'h0, 0, 1, 0, 64'h0);
    check("ill_w_fault", r_fault,    F_ILL);
    check("ill_w_done",  r_done_cyc, 1);

    // Load and store together
    do_access(0, 1, 1, 0, W_W, 32'h100, 64'h0, 0, 1, 0, 64'h0);
    check("ill_ls_fault", r_fault, F_ILL);
    check("ill_ls_req",   r_req,   1'b0);

    // Grant delayed 4 cycles, error response
    do_access(0, 1, 0, 0, W_W, 32'h100, 64'h0, 4, 1, 1, 64'h1111_2222);
    check("err_done",  r_done_cyc, 7);
    check("err_fault", r_fault,    F_BUS);
    check("err_data",  r_ldata,    64'h0);

    // No response: timeout
    do_access(0, 1, 0, 0, W_W, 32'h100, 64'h0, 0, 0, 0, 64'h0);
    check("tmo_done",  r_done_cyc,    9);
    check("tmo_fault", r_fault,       F_BUS);
    check("tmo_req",   r_req_at_done, 1'b0);

    // XLEN=64 LWU / LW 0x1004
    do_access(1, 1, 0, 1, W_W, 32'h1004, 64'h0, 0, 1, 0, 64'hF000_0001_0000_0000);
    check("lwu_data", r_ldata, 64'h0000_0000_F000_0001);
    check("lwu_addr", r_addr,  32'h1000);
    check("lwu_be",   r_be,    8'hF0);
    do_access(1, 1, 0, 0, W_W, 32'h1004, 64'h0, 0, 1, 0, 64'hF000_0001_0000_0000);
    check("lw64_data", r_ldata, 64'hFFFF_FFFF_F000_0001);

    // XLEN=64 SD 0x1008, SW 0x1004
    do_access(1, 0, 1, 0, W_D, 32'h1008, 64'h1122_3344_5566_7788, 0, 1, 0, 64'h0);
    check("sd_be",    r_be,    8'hFF);
    check("sd_addr",  r_addr,  32'h1008);
    check("sd_wdata", r_wdata, 64'h1122_3344_5566_7788);
    check("sd_fault", r_fault, F_NONE);
    do_access(1, 0, 1, 0, W_W, 32'h1004, 64'h0000_0000_AABB_CCDD, 0, 1, 0, 64'h0);
    check("sw64_be",    r_be,    8'hF0);
    check("sw64_wdata", r_wdata, 64'hAABB_CCDD_AABB_CCDD);

    // Reset while in RESP
    pulse_reset();
    sel64 = 0; load = 1'b1; store = 1'b0; uns = 1'b0; width = W_W; addr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    check("rr_req_c1", req32, 1'b1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("rr_stall_resp", stall32, 1'b1);
    rst = 1'b1;
    #1;
    check("rr_req",   req32,   1'b0);
    check("rr_stall", stall32, 1'b0);
    check("rr_done",  done32,  1'b0);
    load = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_access(0, 1, 0, 0, W_W, 32'h204, 64'h0, 0, 1, 0, 64'hCAFE_F00D);
    check("rr_lw_done",  r_done_cyc, 3);
    check("rr_lw_fault", r_fault,    F_NONE);
    check("rr_lw_data",  r_ldata,    64'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
